// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
// Build option: REGFILE_ARB_INIT_SEQ_EN enables the power-up zeroing sequencer.
package regfile_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 4;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_e;

  typedef logic [0:0] req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  // Index of the winner in a two-entry one-hot grant vector.
  function automatic req_idx_t grant_to_idx(input logic [1:0] grant);
    req_idx_t idx;
    idx = grant[1] ? REQ1 : REQ0;
    return idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request and register-file write bus for the write arbiter.
// The master side issues requests and observes the write port; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              writeEnable;
  logic [ADDR_W-1:0] regwriteAddress;
  logic [DATA_W-1:0] regwriteData;
  logic              busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  writeEnable, regwriteAddress, regwriteData, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output writeEnable, regwriteAddress, regwriteData, busy
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   ptr,
  output logic [1:0] grant
);

  // One-hot grant selection from valids and the priority pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: optional zeroing sequencer, then round-robin between two writers.
// Build option: REGFILE_ARB_INIT_SEQ_EN compiles in the INIT sequencer; otherwise reset lands in ARB.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);

`ifdef REGFILE_ARB_INIT_SEQ_EN
  localparam arb_state_e RESET_STATE = INIT;
`else
  localparam arb_state_e RESET_STATE = ARB;
`endif

  arb_state_e        state_r;
  arb_state_e        state_next_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              cnt_last_s;
  logic              init_we_s;
  logic              in_arb_s;
  req_idx_t          ptr_r;
  logic [1:0]        grant_s;
  logic              ready0_s;
  logic              ready1_s;
  logic              xfer0_s;
  logic              xfer1_s;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;

  assign cnt_last_s = (cnt_r == ADDR_W'(NUM_REGS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: INIT leaves after the last entry, ARB is terminal.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (cnt_last_s) begin
          state_next_s = ARB;
        end else begin
          state_next_s = INIT;
        end
      end
      ARB:     state_next_s = ARB;
      default: state_next_s = RESET_STATE;
    endcase
  end

  // FSM outputs: sequencer strobe and arbitration enable.
  always_comb begin
    init_we_s = 1'b0;
    in_arb_s  = 1'b0;
    case (state_r)
`ifdef REGFILE_ARB_INIT_SEQ_EN
      INIT:    init_we_s = 1'b1;
`else
      INIT:    init_we_s = 1'b0;
`endif
      ARB:     in_arb_s  = 1'b1;
      default: in_arb_s  = 1'b0;
    endcase
  end

`ifdef REGFILE_ARB_INIT_SEQ_EN
  // Init address counter walking every entry once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {ADDR_W{1'b0}};
    end else if (init_we_s && !cnt_last_s) begin
      cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign cnt_r = {ADDR_W{1'b0}};
`endif

  rr_arbiter2 u_rr (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Readies are gated by the reset pin so they drop at once when reset asserts.
  assign ready0_s = in_arb_s & reset & grant_s[0];
  assign ready1_s = in_arb_s & reset & grant_s[1];
  assign xfer0_s  = bus.req0_valid & ready0_s;
  assign xfer1_s  = bus.req1_valid & ready1_s;

  // Round-robin pointer moves to the loser after every transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= REQ0;
    end else if (xfer0_s || xfer1_s) begin
      ptr_r <= ~grant_to_idx(grant_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r   <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (init_we_s) begin
      we_r   <= 1'b1;
      addr_r <= cnt_r;
      data_r <= {DATA_W{1'b0}};
    end else if (xfer0_s) begin
      we_r   <= 1'b1;
      addr_r <= bus.req0_addr;
      data_r <= bus.req0_data;
    end else if (xfer1_s) begin
      we_r   <= 1'b1;
      addr_r <= bus.req1_addr;
      data_r <= bus.req1_data;
    end else begin
      we_r   <= 1'b0;
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  assign bus.req0_ready      = ready0_s;
  assign bus.req1_ready      = ready1_s;
  assign bus.writeEnable     = we_r;
  assign bus.regwriteAddress = addr_r;
  assign bus.regwriteData    = data_r;
  assign bus.busy            = init_we_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed table, corner sequences, random vs. model.
// Build option: REGFILE_ARB_INIT_SEQ_EN selects the init-sequencer checks.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [3:0] mem [8];

  regfile_write_arbiter_if #(.ADDR_W(3), .DATA_W(4)) bus ();

  regfile_write_arbiter #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file fed from the write port.
  always @(negedge clk) begin
    if (bus.writeEnable === 1'b1) mem[bus.regwriteAddress] = bus.regwriteData;
  end

  typedef struct {
    logic       v0;
    logic [2:0] a0;
    logic [3:0] d0;
    logic       v1;
    logic [2:0] a1;
    logic [3:0] d1;
    logic       r0;
    logic       r1;
    logic       we;
    logic [2:0] ea;
    logic [3:0] ed;
  } vec_t;

  function automatic vec_t mkv(input logic v0, input logic [2:0] a0, input logic [3:0] d0,
                               input logic v1, input logic [2:0] a1, input logic [3:0] d1,
                               input logic r0, input logic r1, input logic we,
                               input logic [2:0] ea, input logic [3:0] ed);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests (called just after a rising edge), check readies then the write port.
  task automatic apply(input vec_t v, input string tag);
    bus.req0_valid = v.v0; bus.req0_addr = v.a0; bus.req0_data = v.d0;
    bus.req1_valid = v.v1; bus.req1_addr = v.a1; bus.req1_data = v.d1;
    @(negedge clk);
    chk({tag, ".ready0"}, int'(bus.req0_ready), int'(v.r0));
    chk({tag, ".ready1"}, int'(bus.req1_ready), int'(v.r1));
    @(posedge clk);
    #1;
    chk({tag, ".we"}, int'(bus.writeEnable), int'(v.we));
    if (v.we) begin
      chk({tag, ".addr"}, int'(bus.regwriteAddress), int'(v.ea));
      chk({tag, ".data"}, int'(bus.regwriteData), int'(v.ed));
    end
  endtask

  vec_t tbl [11];

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 4'h1;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 4'h2;
    reset = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.we", int'(bus.writeEnable), 0);
    chk("rst.addr", int'(bus.regwriteAddress), 0);
    chk("rst.data", int'(bus.regwriteData), 0);
    chk("rst.ready0", int'(bus.req0_ready), 0);
    chk("rst.ready1", int'(bus.req1_ready), 0);

`ifdef REGFILE_ARB_INIT_SEQ_EN
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("init.busy", int'(bus.busy), 1);
      chk("init.ready0", int'(bus.req0_ready), 0);
      @(posedge clk);
      #1;
      chk("init.we", int'(bus.writeEnable), 1);
      chk("init.addr", int'(bus.regwriteAddress), k);
      chk("init.data", int'(bus.regwriteData), 0);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    chk("init.busy_done", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midinit.addr4", int'(bus.regwriteAddress), 4);
    #2;
    reset = 1'b0;
    #1;
    chk("midinit.we", int'(bus.writeEnable), 0);
    chk("midinit.addr", int'(bus.regwriteAddress), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("restart.addr", int'(bus.regwriteAddress), k);
      chk("restart.we", int'(bus.writeEnable), 1);
    end
`else
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd6; bus.req1_data = 4'hB;
    reset = 1'b1;
    #1;
    chk("first.busy", int'(bus.busy), 0);
    chk("first.ready1", int'(bus.req1_ready), 1);
    @(posedge clk);
    #1;
    chk("first.we", int'(bus.writeEnable), 1);
    chk("first.addr", int'(bus.regwriteAddress), 6);
    chk("first.data", int'(bus.regwriteData), 11);
    bus.req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("idle.we", int'(bus.writeEnable), 0);
      chk("idle.busy", int'(bus.busy), 0);
    end
`endif

    // Pointer is at requester 0 here on both builds.
    tbl[0]  = mkv(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    tbl[1]  = mkv(1'b1, 3'd5, 4'hA, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd5, 4'hA);
    tbl[2]  = mkv(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    tbl[3]  = mkv(1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 4'h3, 1'b0, 1'b1, 1'b1, 3'd7, 4'h3);
    tbl[4]  = mkv(1'b1, 3'd1, 4'h1, 1'b1, 3'd2, 4'h2, 1'b1, 1'b0, 1'b1, 3'd1, 4'h1);
    tbl[5]  = mkv(1'b1, 3'd1, 4'h1, 1'b1, 3'd2, 4'h2, 1'b0, 1'b1, 1'b1, 3'd2, 4'h2);
    tbl[6]  = mkv(1'b1, 3'd1, 4'h1, 1'b1, 3'd2, 4'h2, 1'b1, 1'b0, 1'b1, 3'd1, 4'h1);
    tbl[7]  = mkv(1'b1, 3'd1, 4'h1, 1'b1, 3'd2, 4'h2, 1'b0, 1'b1, 1'b1, 3'd2, 4'h2);
    tbl[8]  = mkv(1'b1, 3'd3, 4'h6, 1'b1, 3'd3, 4'h9, 1'b1, 1'b0, 1'b1, 3'd3, 4'h6);
    tbl[9]  = mkv(1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 4'h9, 1'b0, 1'b1, 1'b1, 3'd3, 4'h9);
    tbl[10] = mkv(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    @(negedge clk);
    chk("sameaddr.mem3", int'(mem[3]), 9);

    // Reset in ARB with a request pending, then random traffic against the model.
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd4; bus.req0_data = 4'hF;
    reset = 1'b0;
    #1;
    chk("arbrst.ready0", int'(bus.req0_ready), 0);
    @(posedge clk);
    #1;
    chk("arbrst.we", int'(bus.writeEnable), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
`ifdef REGFILE_ARB_INIT_SEQ_EN
    chk("arbrst.initaddr", int'(bus.regwriteAddress), 0);
    bus.req0_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
`else
    chk("arbrst.regrant", int'(bus.regwriteAddress), 4);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
`endif
    begin
      int   ptr;
      int   win;
      bit   p0, p1;
      vec_t v;
      ptr = 0;
`ifndef REGFILE_ARB_INIT_SEQ_EN
      ptr = 1;
`endif
      p0 = 1'b0; p1 = 1'b0;
      v = mkv(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
      for (int c = 0; c < 300; c++) begin
        if (!p0) begin
          v.v0 = ($urandom_range(0, 2) != 0);
          v.a0 = 3'($urandom_range(0, 7));
          v.d0 = 4'($urandom_range(0, 15));
        end
        if (!p1) begin
          v.v1 = ($urandom_range(0, 2) != 0);
          v.a1 = 3'($urandom_range(0, 7));
          v.d1 = 4'($urandom_range(0, 15));
        end
        if (v.v0 && v.v1) win = ptr;
        else if (v.v0)    win = 0;
        else if (v.v1)    win = 1;
        else              win = -1;
        v.r0 = (win == 0);
        v.r1 = (win == 1);
        v.we = (win >= 0);
        v.ea = (win == 1) ? v.a1 : v.a0;
        v.ed = (win == 1) ? v.d1 : v.d0;
        apply(v, "rnd");
        if (win >= 0) ptr = 1 - win;
        p0 = v.v0 && (win != 0);
        p1 = v.v1 && (win != 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8: number of register-file entries sequenced.
REQ-002 The block SHALL have parameter ADDR_W, default 3: register address width.
REQ-003 The block SHALL have parameter DATA_W, default 4: register data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-006 req0_valid / req1_valid  input  1  write request from requester 0 (ALU writeback) or requester 1 (load/IO).
REQ-007 req0_addr / req1_addr  input  ADDR_W  target register.
REQ-008 req0_data / req1_data  input  DATA_W  write data.
REQ-009 req0_ready / req1_ready  output  1  grant; a transfer occurs when valid and ready are both 1 on a rising edge.
REQ-010 writeEnable  output  1  register-file write strobe (registered).
REQ-011 regwriteAddress  output  ADDR_W  register-file write address (registered).
REQ-012 regwriteData  output  DATA_W  register-file write data (registered).
REQ-013 busy  output  1  1 while the init sequencer is running.

Function
REQ-014 The FSM SHALL have states INIT and ARB; INIT exits to ARB after writing entry NUM_REGS-1; ARB persists until reset.
REQ-015 In INIT, a counter SHALL walk 0..NUM_REGS-1, one entry per cycle, driving writeEnable=1, regwriteAddress=counter, regwriteData=0.
REQ-016 In INIT, req0_ready and req1_ready SHALL be 0 and busy SHALL be 1.
REQ-017 In ARB, readies SHALL be combinational from valids and the priority pointer: exactly one ready is 1 when either valid is 1; both 0 when neither valid is 1.
REQ-018 With one valid, that requester SHALL be granted regardless of pointer.
REQ-019 With both valid, the requester indicated by the pointer SHALL be granted; the other SHALL hold its request stable until granted.
REQ-020 After each transfer, the pointer SHALL point to the non-granted requester (round-robin); with no transfer, the pointer SHALL hold.
REQ-021 A transfer SHALL appear on writeEnable/regwriteAddress/regwriteData exactly one cycle after the accepting edge; writeEnable SHALL be 0 in any cycle following no transfer.
REQ-022 Both requesters targeting the same address SHALL be serialised; the later write SHALL win in the register file.
REQ-023 Sustained throughput SHALL be one write per cycle; a requester under contention SHALL wait at most one cycle.
REQ-024 Out-of-range addresses (>= NUM_REGS) SHALL be forwarded unchanged.

Reset
REQ-025 Asserting reset SHALL asynchronously set: writeEnable=0, regwriteAddress=0, regwriteData=0, counter=0, pointer=requester 0, FSM=INIT (or ARB per REQ-028), readies=0.
REQ-026 Reset asserted mid-INIT or mid-ARB SHALL abandon any pending output write; the sequence SHALL restart from entry 0 after release.
REQ-027 The first INIT write SHALL occur on the first rising edge after reset release.

Configuration
REQ-028 With macro REGFILE_ARB_INIT_SEQ_EN defined, the INIT sequencer SHALL be compiled in as REQ-014..016; without it, the FSM SHALL reset directly into ARB, busy SHALL be tied 0, and no init writes SHALL occur.

Structure
REQ-029 A shared package regfile_pkg SHALL hold the FSM state enum (INIT, ARB), the requester-index type, and the default NUM_REGS/ADDR_W/DATA_W constants.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (two valids and pointer in, one-hot grant out); the sequencer and output registers stay in the top.

Verification
REQ-031 Reset release with INIT enabled -> writeEnable=1 for 8 cycles, addresses 0..7 in order, data 0; busy=1 throughout, readies=0; then busy=0.
REQ-032 Single requester: req0 addr 5 data 4'hA held 1 cycle in ARB -> req0_ready=1 same cycle; next cycle writeEnable=1, addr 5, data 4'hA; following cycle writeEnable=0.
REQ-033 Both valid for 4 cycles (req0 addr 1 data 1, req1 addr 2 data 2, pointer=0) -> grants alternate 0,1,0,1; outputs alternate addr 1/2 one cycle later.
REQ-034 Same-address contention: req0 addr 3 data 4'h6, req1 addr 3 data 4'h9 -> two consecutive writes to 3, second value matches later grant.
REQ-035 Reset asserted mid-INIT at entry 4 -> outputs go 0 immediately without clock; after release, INIT restarts at entry 0.
REQ-036 Build without REGFILE_ARB_INIT_SEQ_EN -> no writes after reset, busy=0, req1 valid on first cycle granted immediately.
